cache_4way_lru: RTL and testbench

Read-only, 4-way set-associative cache with true-LRU replacement and an internal deterministic backing store. It sits between a word-fetch requester and a modelled memory. It returns one 32-bit word per read request and flags whether the request hit. It serves as the 4-way reference point among the team's cache-organisation simulators.

---
 rtl/cache_4way_lru_if.sv | 13 +
 rtl/cache_4way_lru.sv | 133 +++++++++++++
 tb/tb_cache_4way_lru.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/cache_4way_lru_if.sv
// Request/response bundle between a word-fetch requester and cache_4way_lru.
interface cache_4way_lru_if;
    localparam int unsigned ADDR_W = 11;
    localparam int unsigned DATA_W = 32;

    logic              read;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] read_data;
    logic              hit;

    modport master (output read, output addr, input read_data, input hit);
    modport slave  (input read, input addr, output read_data, output hit);
endinterface

// File: rtl/cache_4way_lru.sv
// Read-only 4-way, 4-set cache with true-LRU ages and a synthetic backing store.
// Optional hit/miss counters are enabled by defining CACHE_4WAY_STATS_EN.
module cache_4way_lru (
    input  logic            clk,
    input  logic            rst,
    cache_4way_lru_if.slave bus
`ifdef CACHE_4WAY_STATS_EN
    ,
    output logic [15:0]     hit_count,
    output logic [15:0]     miss_count
`endif
);
    localparam int unsigned WAYS   = 4;
    localparam int unsigned SETS   = 4;
    localparam int unsigned WAY_W  = 2;
    localparam int unsigned IDX_W  = 2;
    localparam int unsigned TAG_W  = 7;
    localparam int unsigned AGE_W  = 2;
    localparam int unsigned DATA_W = 32;

    logic [WAYS-1:0]   r_valid [SETS];
    logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
    logic [DATA_W-1:0] r_data  [SETS][WAYS];
    logic [AGE_W-1:0]  r_age   [SETS][WAYS];
    logic              r_hit;
    logic [DATA_W-1:0] r_read_data;

    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic [DATA_W-1:0] w_fill_word;
    logic              w_hit;
    logic [WAY_W-1:0]  w_hit_way;
    logic              w_has_inv;
    logic [WAY_W-1:0]  w_victim;
    logic [WAY_W-1:0]  w_acc_way;
    logic [AGE_W-1:0]  w_acc_age;
    logic              w_unused_ofs;

    assign w_idx        = bus.addr[3:2];
    assign w_tag        = bus.addr[10:4];
    assign w_fill_word  = {16'hA5A5, 5'b0, bus.addr[10:2], 2'b00};
    assign w_unused_ofs = ^bus.addr[1:0];

    // Tag match and victim choice: lowest invalid way first, else the age-3 way.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        w_has_inv = 1'b0;
        w_victim  = '0;
        for (int w = 0; w < int'(WAYS); w++) begin
            if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
        end
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (!r_valid[w_idx][w]) begin
                w_has_inv = 1'b1;
                w_victim  = WAY_W'(w);
            end
        end
        if (!w_has_inv) begin
            for (int w = 0; w < int'(WAYS); w++) begin
                if (r_age[w_idx][w] == AGE_W'(WAYS - 1)) begin
                    w_victim = WAY_W'(w);
                end
            end
        end
    end

    assign w_acc_way = w_hit ? w_hit_way : w_victim;
    assign w_acc_age = r_age[w_idx][w_acc_way];

    // Lookup, fill and age update; ages stay a permutation of 0..WAYS-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < int'(SETS); s++) begin
                r_valid[s] <= '0;
                for (int w = 0; w < int'(WAYS); w++) begin
                    r_tag[s][w]  <= '0;
                    r_data[s][w] <= '0;
                    r_age[s][w]  <= AGE_W'(w);
                end
            end
            r_hit       <= 1'b0;
            r_read_data <= '0;
        end else if (bus.read) begin
            for (int w = 0; w < int'(WAYS); w++) begin
                if (WAY_W'(w) == w_acc_way) begin
                    r_age[w_idx][w] <= '0;
                end else if (r_age[w_idx][w] < w_acc_age) begin
                    r_age[w_idx][w] <= r_age[w_idx][w] + AGE_W'(1);
                end
            end
            if (w_hit) begin
                r_hit       <= 1'b1;
                r_read_data <= r_data[w_idx][w_hit_way];
            end else begin
                r_hit                     <= 1'b0;
                r_read_data               <= w_fill_word;
                r_valid[w_idx][w_victim]  <= 1'b1;
                r_tag[w_idx][w_victim]    <= w_tag;
                r_data[w_idx][w_victim]   <= w_fill_word;
            end
        end
    end

    assign bus.hit       = r_hit;
    assign bus.read_data = r_read_data;

`ifdef CACHE_4WAY_STATS_EN
    logic [15:0] r_hit_count;
    logic [15:0] r_miss_count;

    // Saturating request counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (bus.read) begin
            if (w_hit && (r_hit_count != 16'hFFFF)) begin
                r_hit_count <= r_hit_count + 16'd1;
            end
            if (!w_hit && (r_miss_count != 16'hFFFF)) begin
                r_miss_count <= r_miss_count + 16'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif
endmodule

// File: tb/tb_cache_4way_lru.sv
// Directed and random bench for cache_4way_lru against a recency-list model.
module tb_cache_4way_lru;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_4way_lru_if bus ();

`ifdef CACHE_4WAY_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    cache_4way_lru dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus)
`ifdef CACHE_4WAY_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Model: per set, tags ordered most-recent first.
    logic [6:0]  m_tag [4][4];
    int          m_cnt [4];
    logic        m_hit;
    logic [31:0] m_data;
    logic [15:0] m_hits;
    logic [15:0] m_misses;

    function automatic logic [31:0] backing(input logic [10:0] a);
        return {16'hA5A5, 5'b0, a[10:2], 2'b00};
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 4; s++) m_cnt[s] = 0;
        m_hit    = 1'b0;
        m_data   = '0;
        m_hits   = '0;
        m_misses = '0;
    endtask

    task automatic model_access(input logic [10:0] a);
        int s;
        int pos;
        logic [6:0] t;
        s   = int'(a[3:2]);
        t   = a[10:4];
        pos = -1;
        for (int i = 0; i < m_cnt[s]; i++) if (m_tag[s][i] == t) pos = i;
        if (pos >= 0) begin
            m_hit = 1'b1;
            for (int i = pos; i > 0; i--) m_tag[s][i] = m_tag[s][i-1];
            if (m_hits != 16'hFFFF) m_hits++;
        end else begin
            m_hit = 1'b0;
            if (m_cnt[s] < 4) m_cnt[s]++;
            for (int i = m_cnt[s] - 1; i > 0; i--) m_tag[s][i] = m_tag[s][i-1];
            if (m_misses != 16'hFFFF) m_misses++;
        end
        m_tag[s][0] = t;
        m_data = backing(a);
    endtask

    task automatic check_outputs(input string tag);
        check32({tag, ".hit"}, {31'b0, bus.hit}, {31'b0, m_hit});
        check32({tag, ".data"}, bus.read_data, m_data);
`ifdef CACHE_4WAY_STATS_EN
        check32({tag, ".hits"}, {16'b0, hit_count}, {16'b0, m_hits});
        check32({tag, ".misses"}, {16'b0, miss_count}, {16'b0, m_misses});
`endif
    endtask

    task automatic do_read(input logic [10:0] a, input string tag);
        @(negedge clk);
        bus.read = 1'b1;
        bus.addr = a;
        model_access(a);
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    // Directed read with expectations fixed by the address rules alone.
    task automatic read_exp(input logic [10:0] a, input logic exp_hit, input string tag);
        do_read(a, tag);
        check32({tag, ".hit_c"}, {31'b0, bus.hit}, {31'b0, exp_hit});
        check32({tag, ".data_c"}, bus.read_data, backing(a));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.read = 1'b0;
            bus.addr = 11'($urandom);
            @(posedge clk);
            #1;
            check_outputs("hold");
        end
    endtask

    // Asynchronous reset between edges, with a read held high while in reset.
    task automatic reset_pulse();
        @(negedge clk);
        bus.read = 1'b0;
        @(posedge clk);
        #2;
        rst      = 1'b0;
        bus.read = 1'b1;
        bus.addr = 11'h034;
        model_reset();
        #1;
        check_outputs("rst_async");
        @(posedge clk);
        #1;
        check_outputs("rst_read_ignored");
        @(negedge clk);
        rst      = 1'b1;
        bus.read = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [10:0] ra;
        rst      = 1'b0;
        bus.read = 1'b0;
        bus.addr = '0;
        model_reset();
        #12;
        check_outputs("por");
        @(negedge clk);
        rst = 1'b1;

        read_exp(11'h034, 1'b0, "fill034");
        read_exp(11'h038, 1'b0, "fill038");
        read_exp(11'h03C, 1'b0, "fill03C");
        read_exp(11'h040, 1'b0, "fill040");
        read_exp(11'h034, 1'b1, "hit034");
        read_exp(11'h035, 1'b1, "hit035");
        idle(3);

        reset_pulse();
        read_exp(11'h034, 1'b0, "cold034");

        reset_pulse();
        read_exp(11'h004, 1'b0, "ev004");
        read_exp(11'h014, 1'b0, "ev014");
        read_exp(11'h024, 1'b0, "ev024");
        read_exp(11'h034, 1'b0, "ev034");
        read_exp(11'h044, 1'b0, "ev044");
        read_exp(11'h004, 1'b0, "ev004b");
        read_exp(11'h024, 1'b1, "ev024hit");

        reset_pulse();
        read_exp(11'h004, 1'b0, "lru004");
        read_exp(11'h014, 1'b0, "lru014");
        read_exp(11'h024, 1'b0, "lru024");
        read_exp(11'h034, 1'b0, "lru034");
        read_exp(11'h004, 1'b1, "lru004hit");
        read_exp(11'h044, 1'b0, "lru044");
        read_exp(11'h004, 1'b1, "lru004hit2");
        read_exp(11'h014, 1'b0, "lru014miss");

        reset_pulse();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(1);
            end else begin
                ra = {7'($urandom_range(0, 7)), 2'($urandom), 2'($urandom)};
                do_read(ra, "rand");
            end
            if (i == 200) reset_pulse();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
